multiplier: RTL and testbench
=============================

# multiplier

Sequential 32×32 signed multiplier using radix-4 modified Booth recoding. It is the multiply half of the multdiv unit and sits beside `divider`, sharing its operand and result conventions. It latches both operands on `ctrl_MULT`, runs 16 add/shift iterations, and presents the low 32 bits of the product with a one-cycle ready pulse. It flags an exception when the full 64-bit product does not fit in 32 signed bits.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported; the parameter exists for the shared package.
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; takes priority over everything.
- `data_operandA`  in  32  multiplicand, two's complement; sampled only on a `ctrl_MULT` edge.
- `data_operandB`  in  32  multiplier, two's complement; sampled only on a `ctrl_MULT` edge.
- `ctrl_MULT`  in  1  start strobe; one cycle high is sufficient.
- `data_result`  out  32  product bits [31:0]; registered.
- `data_exception`  out  1  overflow flag; registered; valid with `data_result`.
- `data_resultRDY`  out  1  one-cycle pulse; result is valid in that cycle.

## Operation
- **States:** IDLE, BUSY, DONE.
  - IDLE → BUSY on `ctrl_MULT`.
  - BUSY stays in BUSY while the iteration count is below 15.
  - BUSY → DONE after iteration 15.
  - DONE → IDLE unconditionally.
  - `ctrl_MULT` in any state reloads the operands and enters BUSY with count 0. An in-flight operation is abandoned and no RDY is issued for it.
- **Load:**
  - acc (34 bits) = 0.
  - Q = `data_operandB`.
  - q₋₁ = 0.
  - M = `data_operandA` sign-extended to 34 bits.
  - count = 0.
- **Iteration, recode {Q[1], Q[0], q₋₁}:**
  - 000 or 111 → +0
  - 001 or 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101 or 110 → −M
- **Negation:** invert the addend and set carry-in to 1. Each iteration adds into acc at 34-bit width.
- **Shift:** arithmetic right shift of {acc, Q, q₋₁} by 2, then count increments.
- **Product:** after 16 iterations, P[63:0] = {acc[31:0], Q}.
- **Entry to DONE:**
  - `data_result` ← P[31:0].
  - `data_exception` ← 1 unless P[63:31] is all zeros or all ones.
- **Hold:** `data_result` and `data_exception` keep their values until the next DONE entry or `reset`. A restart does not clear them.
- **Ready:** `data_resultRDY` = (state == DONE).
- **Reset:**
  - state = IDLE, count = 0, acc/Q/q₋₁/M = 0.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0.
  - Reset mid-BUSY aborts with no RDY.
  - `reset` and `ctrl_MULT` both high → reset wins.

## Timing
- Cycle 0: `ctrl_MULT` high; operands are sampled at the end of cycle 0.
- Cycles 1–16: BUSY, with count 0..15. One iteration commits per edge.
- Cycle 17: DONE. `data_resultRDY` = 1 and `data_result`/`data_exception` are valid.
- Cycle 18: IDLE. RDY = 0; result and exception still held.
- Latency is 17 cycles from the start strobe to RDY. Back-to-back issue is allowed: `ctrl_MULT` in cycle 17 starts a new operation, and RDY still pulses in cycle 17.
- Operand changes outside the sampling edge have no effect.

## Structure
- **Shared package `multdiv_pkg`:**
  - `WIDTH` = 32.
  - Iteration count constant 16.
  - State enum {IDLE, BUSY, DONE}.
  - Booth select enum {ZERO, POS1, POS2, NEG1, NEG2}.
- **Sub-module `booth_recoder`** (combinational):
  - Inputs: 3 recode bits and M.
  - Outputs: 34-bit addend (0, ±M, ±2M before inversion), invert flag, and carry-in.
- **Adder:** reuse the existing `cla`, widened to 34 bits or chained.
- **Registers:** use the existing `register` cells for acc/Q/M and the result. The state and 4-bit counter live in the top module.

## Test plan
- **Basic positive product:** A=3, B=5 with `ctrl_MULT` for one cycle.
  - RDY in exactly cycle 17 and only then; result 0x0000000F, exception 0.
- **Mixed signs and zero:**
  - A=−7, B=6 → result 0xFFFFFFD6, exception 0.
  - A=0, B=0x80000000 → result 0, exception 0.
- **Overflow:**
  - A=0x80000000, B=0xFFFFFFFF → result 0x80000000, exception 1.
  - A=0x00010000, B=0x00010000 → result 0, exception 1.
  - A=0x80000000, B=1 → exception 0.
- **Restart mid-operation:** start 3×5, then assert `ctrl_MULT` in cycle 6 with 4×4.
  - No RDY in cycle 17; RDY 17 cycles after the second strobe with result 16.
  - Operand changes while BUSY are ignored.
- **Reset mid-operation:** assert `reset` in cycle 9.
  - All outputs go to 0 the next cycle and no RDY follows.
  - `reset` and `ctrl_MULT` high together → stays IDLE.
- **Back-to-back with random operands:** issue `ctrl_MULT` in the RDY cycle each time, with random signed pairs.
  - Each RDY pulse is one cycle wide.
  - Result and exception match a 64-bit golden model.
  - Outputs hold between pulses.

Source files
------------

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
// multdiv_pkg : shared widths, counts and enums for the multiply/divide unit
// Revision    : 1.0
// ============================================================================
package multdiv_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 16;
  localparam logic [3:0] LAST_COUNT = 4'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_sel_e;

endpackage
`default_nettype wire

// File: rtl/booth_recoder.sv
`default_nettype none
// ============================================================================
// booth_recoder : radix-4 Booth digit select; addend is 0, M or 2M with the
//                 sign carried separately as invert flag and carry-in
// Revision      : 1.0
// ============================================================================
module booth_recoder #(
  parameter int WIDTH = 34
) (
  input  logic [2:0]       bits_i,
  input  logic [WIDTH-1:0] m_i,
  output logic [WIDTH-1:0] addend_o,
  output logic             invert_o,
  output logic             cin_o
);
  import multdiv_pkg::*;

  booth_sel_e sel;

  always_comb begin
    sel = ZERO;
    case (bits_i)
      3'b001, 3'b010: sel = POS1;
      3'b011:         sel = POS2;
      3'b100:         sel = NEG2;
      3'b101, 3'b110: sel = NEG1;
      default:        sel = ZERO;
    endcase
  end

  always_comb begin
    addend_o = '0;
    case (sel)
      POS1, NEG1: addend_o = m_i;
      POS2, NEG2: addend_o = m_i << 1;
      default:    addend_o = '0;
    endcase
  end

  assign invert_o = (sel == NEG1) || (sel == NEG2);
  assign cin_o    = invert_o;

endmodule
`default_nettype wire

// File: rtl/cla.sv
`default_nettype none
// ============================================================================
// cla      : generate/propagate adder, sum = a + b + cin (carry-out dropped)
// Revision : 1.0
// ============================================================================
module cla #(
  parameter int WIDTH = 34
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o
);

  logic [WIDTH-1:0] w_gen;
  logic [WIDTH-1:0] w_prop;

  assign w_gen  = a_i & b_i;
  assign w_prop = a_i ^ b_i;

  always_comb begin : p_carry
    logic carry;
    sum_o = '0;
    carry = cin_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = w_prop[i] ^ carry;
      carry    = w_gen[i] | (w_prop[i] & carry);
    end
  end

endmodule
`default_nettype wire

// File: rtl/register.sv
`default_nettype none
// ============================================================================
// register : enabled storage cell with synchronous active-high reset
// Revision : 1.0
// ============================================================================
module register #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/multiplier.sv
`default_nettype none
// ============================================================================
// multiplier : sequential 32x32 signed radix-4 Booth multiplier, 17-cycle
//              latency, low product word plus 32-bit overflow flag
// Revision   : 1.0
// ============================================================================
module multiplier #(
  parameter int WIDTH = multdiv_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  import multdiv_pkg::*;

  localparam int ACC_W = WIDTH + 2;

  mult_state_e      state_q, state_d;
  logic [3:0]       count_q, count_d;

  logic [ACC_W-1:0] acc_q, acc_d, m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;

  logic             w_load, w_step, w_finish;
  logic [ACC_W-1:0] w_addend, w_addend_x, w_sum, w_acc_shift;
  logic [WIDTH-1:0] w_q_shift;
  logic             w_invert, w_cin;
  logic [WIDTH:0]   w_prod_hi;
  logic             w_overflow;

  // A strobe in any state wins over the running iteration and abandons it.
  assign w_load   = ctrl_MULT;
  assign w_step   = (state_q == BUSY) && !ctrl_MULT;
  assign w_finish = w_step && (count_q == LAST_COUNT);

  booth_recoder #(.WIDTH(ACC_W)) u_recoder (
    .bits_i   ({q_q[1:0], qm1_q}),
    .m_i      (m_q),
    .addend_o (w_addend),
    .invert_o (w_invert),
    .cin_o    (w_cin)
  );

  assign w_addend_x = w_addend ^ {ACC_W{w_invert}};

  cla #(.WIDTH(ACC_W)) u_cla (
    .a_i   (acc_q),
    .b_i   (w_addend_x),
    .cin_i (w_cin),
    .sum_o (w_sum)
  );

  assign w_acc_shift = {{2{w_sum[ACC_W-1]}}, w_sum[ACC_W-1:2]};
  assign w_q_shift   = {w_sum[1:0], q_q[WIDTH-1:2]};

  // Product bits [63:31] as they will stand after the final iteration.
  assign w_prod_hi  = {w_acc_shift[WIDTH-1:0], w_q_shift[WIDTH-1]};
  assign w_overflow = !((&w_prod_hi) || !(|w_prod_hi));

  assign acc_d = w_load ? '0 : w_acc_shift;
  assign q_d   = w_load ? data_operandB : w_q_shift;
  assign qm1_d = w_load ? 1'b0 : q_q[1];
  assign m_d   = {{2{data_operandA[WIDTH-1]}}, data_operandA};

  register #(.WIDTH(ACC_W)) u_acc (
    .clock, .reset, .en_i(w_load | w_step), .d_i(acc_d), .q_o(acc_q)
  );
  register #(.WIDTH(WIDTH)) u_q (
    .clock, .reset, .en_i(w_load | w_step), .d_i(q_d), .q_o(q_q)
  );
  register #(.WIDTH(1)) u_qm1 (
    .clock, .reset, .en_i(w_load | w_step), .d_i(qm1_d), .q_o(qm1_q)
  );
  register #(.WIDTH(ACC_W)) u_m (
    .clock, .reset, .en_i(w_load), .d_i(m_d), .q_o(m_q)
  );
  register #(.WIDTH(WIDTH)) u_result (
    .clock, .reset, .en_i(w_finish), .d_i(w_q_shift), .q_o(data_result)
  );
  register #(.WIDTH(1)) u_exception (
    .clock, .reset, .en_i(w_finish), .d_i(w_overflow), .q_o(data_exception)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (ctrl_MULT) begin
      state_d = BUSY;
      count_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        BUSY: begin
          if (count_q == LAST_COUNT) begin
            state_d = DONE;
            count_d = 4'd0;
          end else begin
            count_d = count_q + 4'd1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_multiplier.sv
`default_nettype none
// ============================================================================
// tb_multiplier : directed self-checking bench for the Booth multiplier
// Revision      : 1.0
// ============================================================================
module tb_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_MULT = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clock = ~clock;

  multiplier #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Strobe is raised for one cycle; returns at the negedge of cycle 1.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
  endtask

  // Called at cycle 1; lat is the cycle number RDY is seen in, 0 on timeout.
  task automatic wait_rdy(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (data_resultRDY) begin
        lat = k;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    tests_run++;
    if (data_result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_result: got %h want %h", data_result, 32'h0);
    end
    tests_run++;
    if (data_exception !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_exception: got %b want 0", data_exception);
    end
    tests_run++;
    if (data_resultRDY !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rdy: got %b want 0", data_resultRDY);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if (data_resultRDY !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_rdy: got %b want 0", data_resultRDY);
    end
  endtask

  task automatic test_basic();
    int lat;
    start_op(32'd3, 32'd5);
    wait_rdy(lat);
    tests_run++;
    if (lat !== 17) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want 17", lat);
    end
    tests_run++;
    if (data_result !== 32'h0000000F) begin
      tests_failed++;
      $display("FAIL basic_result: got %h want %h", data_result, 32'h0000000F);
    end
    tests_run++;
    if (data_exception !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_exception: got %b want 0", data_exception);
    end
    @(negedge clock);
    tests_run++;
    if (data_resultRDY !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_rdy_width: got %b want 0", data_resultRDY);
    end
    tests_run++;
    if (data_result !== 32'h0000000F) begin
      tests_failed++;
      $display("FAIL basic_hold: got %h want %h", data_result, 32'h0000000F);
    end
  endtask

  // Mixed signs, zero and overflow boundaries, each run in isolation.
  task automatic test_vectors();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [31:0] vr [6];
    logic        ve [6];
    int lat;
    va = '{32'hFFFFFFF9, 32'h00000000, 32'h80000000, 32'h00010000, 32'h80000000, 32'hFFFF0000};
    vb = '{32'h00000006, 32'h80000000, 32'hFFFFFFFF, 32'h00010000, 32'h00000001, 32'h00008000};
    vr = '{32'hFFFFFFD6, 32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000};
    ve = '{1'b0,         1'b0,         1'b1,         1'b1,         1'b0,         1'b0};
    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i]);
      wait_rdy(lat);
      tests_run++;
      if (lat !== 17) begin
        tests_failed++;
        $display("FAIL vec%0d_latency: got %0d want 17", i, lat);
      end
      tests_run++;
      if (data_result !== vr[i]) begin
        tests_failed++;
        $display("FAIL vec%0d_result: got %h want %h", i, data_result, vr[i]);
      end
      tests_run++;
      if (data_exception !== ve[i]) begin
        tests_failed++;
        $display("FAIL vec%0d_exception: got %b want %b", i, data_exception, ve[i]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_restart();
    int lat;
    start_op(32'd3, 32'd5);
    repeat (4) @(negedge clock);
    start_op(32'd4, 32'd4);
    data_operandA = 32'h12345678;
    data_operandB = 32'h7FFFFFFF;
    wait_rdy(lat);
    tests_run++;
    if (lat !== 17) begin
      tests_failed++;
      $display("FAIL restart_latency: got %0d want 17", lat);
    end
    tests_run++;
    if (data_result !== 32'd16) begin
      tests_failed++;
      $display("FAIL restart_result: got %h want %h", data_result, 32'd16);
    end
    tests_run++;
    if (data_exception !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_exception: got %b want 0", data_exception);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    start_op(32'h7FFFFFFF, 32'd2);
    wait_rdy(lat);
    tests_run++;
    if (data_result !== 32'hFFFFFFFE || data_exception !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_op: got %h/%b want fffffffe/1", data_result, data_exception);
    end
    start_op(32'd3, 32'd5);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    tests_run++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: got %h/%b/%b want 0/0/0",
               data_result, data_exception, data_resultRDY);
    end
    pulses = 0;
    repeat (25) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_rdy: got %0d pulses want 0", pulses);
    end
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd5;
    reset     = 1'b1;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    ctrl_MULT = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    tests_run++;
    if (pulses !== 0 || data_result !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_over_start: got %0d pulses result %h want 0 pulses result 0",
               pulses, data_result);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] vr [5];
    logic        ve [5];
    int lat;
    va = '{32'd100,       32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00012345, 32'hFFFF0000};
    vb = '{32'hFFFFFF38,  32'h00000002, 32'hFFFFFFFF, 32'h00006789, 32'h00008000};
    vr = '{32'hFFFFB1E0,  32'hFFFFFFFE, 32'h00000001, 32'h75CCA2ED, 32'h80000000};
    ve = '{1'b0,          1'b1,         1'b0,         1'b0,         1'b0};
    start_op(va[0], vb[0]);
    for (int i = 0; i < 5; i++) begin
      wait_rdy(lat);
      tests_run++;
      if (lat !== 17) begin
        tests_failed++;
        $display("FAIL b2b%0d_latency: got %0d want 17", i, lat);
      end
      tests_run++;
      if (data_result !== vr[i] || data_exception !== ve[i]) begin
        tests_failed++;
        $display("FAIL b2b%0d_result: got %h/%b want %h/%b",
                 i, data_result, data_exception, vr[i], ve[i]);
      end
      if (i < 4) begin
        data_operandA = va[i+1];
        data_operandB = vb[i+1];
        ctrl_MULT     = 1'b1;
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      tests_run++;
      if (data_resultRDY !== 1'b0 || data_result !== vr[i] || data_exception !== ve[i]) begin
        tests_failed++;
        $display("FAIL b2b%0d_pulse_hold: got rdy %b %h/%b want rdy 0 %h/%b",
                 i, data_resultRDY, data_result, data_exception, vr[i], ve[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
